// File: rtl/tqvp_spi_bus_master.sv
// SPI-slave to TinyQV peripheral bus bridge: an external host issues 8/16/32-bit
// peripheral reads and writes via mode-0 SPI frames, with timeout and sticky error.
module tqvp_spi_bus_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [5:0]  address,
    output logic [31:0] data_out,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_in,
    input  logic        data_ready,
    output logic        busy,
    output logic        err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, HDR, WDATA, RTURN, RDATA, DONE} frame_t;
    typedef enum logic {B_IDLE, B_REQ} bus_t;

    frame_t         state_q, state_d;
    bus_t           bstate_q, bstate_d;
    logic           sck_r, cs_r;
    logic           rise, fall, cs_fall;
    logic [5:0]     cnt_q;
    logic [14:0]    hdr_q;
    logic [15:0]    hdr_full;
    logic [6:0]     byte_q;
    logic [31:0]    wdata_q, wdata_nx;
    logic [31:0]    rd_buf_q, rd_data_q, word_src;
    logic           rd_done_q, first_q;
    logic [TW-1:0]  tmo_q;
    logic           launch, launch_wr, hdr_err;
    logic [5:0]     launch_addr;
    logic [1:0]     launch_size;
    logic           rd_miss, tmo_hit, err_set;

    function automatic logic [5:0] frame_bits(input logic [1:0] size);
        case (size)
            2'b00:   return 6'd8;
            2'b01:   return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    function automatic logic [31:0] rd_sel(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {24'h0, d[7:0]};
            2'b01:   return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign rise     = spi_sck & ~sck_r;
    assign fall     = ~spi_sck & sck_r;
    assign cs_fall  = cs_r & ~spi_cs_n;
    assign hdr_full = {hdr_q, spi_mosi};
    assign busy     = (bstate_q == B_REQ);

    // Frame FSM next state and launch decode
    always_comb begin
        state_d   = state_q;
        launch    = 1'b0;
        launch_wr = 1'b0;
        hdr_err   = 1'b0;
        wdata_nx  = wdata_q;
        wdata_nx[{cnt_q[4:3], 3'b000} +: 8] = {byte_q, spi_mosi};
        if (spi_cs_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) state_d = HDR;
                HDR: begin
                    if (rise && cnt_q == 6'd15) begin
                        if (hdr_full[9:8] == 2'b11) begin
                            state_d = DONE;
                            hdr_err = 1'b1;
                        end else if (hdr_full[15]) begin
                            state_d = WDATA;
                        end else begin
                            state_d = RTURN;
                            launch  = 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (rise && cnt_q == frame_bits(hdr_q[9:8]) - 6'd1) begin
                        state_d   = DONE;
                        launch    = 1'b1;
                        launch_wr = 1'b1;
                    end
                end
                RTURN: if (rise && cnt_q == 6'd7) state_d = RDATA;
                RDATA: if (rise && cnt_q == frame_bits(hdr_q[9:8]) - 6'd1) state_d = DONE;
                default: ;
            endcase
        end
    end

    // A read frame launches straight from the live header; a write uses the stored one
    assign launch_addr = launch_wr ? hdr_q[5:0] : hdr_full[5:0];
    assign launch_size = launch_wr ? hdr_q[9:8] : hdr_full[9:8];

    assign word_src = first_q ? (rd_done_q ? rd_data_q : 32'hFFFF_FFFF) : rd_buf_q;
    assign rd_miss  = (state_q == RDATA) && fall && first_q && !rd_done_q;
    assign tmo_hit  = (bstate_q == B_REQ) && !data_ready && (tmo_q == TW'(TIMEOUT - 1));
    assign err_set  = hdr_err | (launch & busy) | rd_miss | tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_r    <= 1'b0;
            cs_r     <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            hdr_q    <= '0;
            byte_q   <= '0;
            wdata_q  <= '0;
            rd_buf_q <= '0;
            first_q  <= 1'b0;
            spi_miso <= 1'b0;
            err      <= 1'b0;
        end else begin
            sck_r   <= spi_sck;
            cs_r    <= spi_cs_n;
            state_q <= state_d;
            if (state_d != state_q) cnt_q <= '0;
            else if (rise)          cnt_q <= cnt_q + 6'd1;
            if (state_q == HDR && rise) hdr_q <= hdr_full[14:0];
            if (state_q == WDATA && rise) begin
                byte_q <= {byte_q[5:0], spi_mosi};
                if (cnt_q[2:0] == 3'd7) wdata_q <= wdata_nx;
            end else if (state_q == HDR && state_d == WDATA) begin
                wdata_q <= '0;
            end
            // Read data is frozen at the first RDATA fall so a late bus result cannot tear a byte
            if (state_q != RDATA && state_d == RDATA) begin
                first_q <= 1'b1;
            end else if (state_q == RDATA && fall) begin
                first_q <= 1'b0;
                if (first_q) rd_buf_q <= word_src;
            end
            if (state_d != RDATA)                 spi_miso <= 1'b0;
            else if (state_q == RDATA && fall)    spi_miso <= word_src[{cnt_q[4:3], ~cnt_q[2:0]}];
            if (err_set)                                  err <= 1'b1;
            else if (state_q == IDLE && state_d == HDR)   err <= 1'b0;
        end
    end

    // Bus FSM: a single outstanding request, released by data_ready or timeout
    always_comb begin
        bstate_d = bstate_q;
        case (bstate_q)
            B_IDLE:  if (launch) bstate_d = B_REQ;
            B_REQ:   if (data_ready || tmo_hit) bstate_d = B_IDLE;
            default: bstate_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bstate_q     <= B_IDLE;
            address      <= '0;
            data_out     <= '0;
            data_write_n <= 2'b11;
            data_read_n  <= 2'b11;
            tmo_q        <= '0;
            rd_data_q    <= '0;
            rd_done_q    <= 1'b0;
        end else begin
            bstate_q <= bstate_d;
            if (bstate_q == B_IDLE && launch) begin
                address <= launch_addr;
                tmo_q   <= '0;
                if (launch_wr) begin
                    data_out     <= wdata_nx;
                    data_write_n <= launch_size;
                end else begin
                    data_read_n <= launch_size;
                    rd_done_q   <= 1'b0;
                end
            end else if (bstate_q == B_REQ) begin
                if (data_ready) begin
                    if (data_read_n != 2'b11) begin
                        rd_data_q <= rd_sel(data_read_n, data_in);
                        rd_done_q <= 1'b1;
                    end
                    data_write_n <= 2'b11;
                    data_read_n  <= 2'b11;
                end else if (tmo_hit) begin
                    if (data_read_n != 2'b11) begin
                        rd_data_q <= 32'hFFFF_FFFF;
                        rd_done_q <= 1'b1;
                    end
                    data_write_n <= 2'b11;
                    data_read_n  <= 2'b11;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tqvp_spi_bus_master.sv
// Bench for tqvp_spi_bus_master: SPI host, peripheral model with programmable
// ready delay, per-cycle bus monitor and frame-level expected-result model.
module tb_tqvp_spi_bus_master;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [5:0]  address;
    logic [31:0] data_out;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_in;
    logic        data_ready;
    logic        busy;
    logic        err;

    int          tests = 0;
    int          fails = 0;
    int          ready_delay = 0;
    int          req_age = 0;
    logic [31:0] periph_data = 32'h0;
    logic        req_active;

    always #5 clk = ~clk;

    tqvp_spi_bus_master #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .address(address),
        .data_out(data_out), .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_in(data_in), .data_ready(data_ready), .busy(busy), .err(err)
    );

    assign req_active = (data_write_n != 2'b11) || (data_read_n != 2'b11);
    assign data_in    = periph_data;
    // Delay 0 means data_ready tied high; negative means it never arrives
    assign data_ready = (ready_delay == 0) ||
                        (ready_delay > 0 && req_active && req_age >= ready_delay);

    always @(posedge clk) req_age <= req_active ? req_age + 1 : 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Completed bus requests, pushed when the request lines return to 11
    logic [5:0]  q_addr[$];
    logic [1:0]  q_code[$];
    bit          q_wr[$];
    logic [31:0] q_data[$];
    int          q_width[$];
    logic [5:0]  c_addr;
    logic [1:0]  c_code;
    bit          c_wr;
    logic [31:0] c_data;
    int          c_width = 0;
    bit          act_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("exclusive_req", {31'b0, (data_write_n != 2'b11) && (data_read_n != 2'b11)}, 32'h0);
            chk("busy_vs_req", {31'b0, busy}, {31'b0, req_active});
            if (req_active && !act_prev) begin
                c_wr    = (data_write_n != 2'b11);
                c_code  = c_wr ? data_write_n : data_read_n;
                c_addr  = address;
                c_data  = data_out;
                c_width = 1;
            end else if (req_active) begin
                chk("hold_addr", {26'b0, address}, {26'b0, c_addr});
                chk("hold_code", {30'b0, c_wr ? data_write_n : data_read_n}, {30'b0, c_code});
                chk("hold_data", data_out, c_data);
                c_width++;
            end else if (act_prev) begin
                q_addr.push_back(c_addr);
                q_code.push_back(c_code);
                q_wr.push_back(c_wr);
                q_data.push_back(c_data);
                q_width.push_back(c_width);
            end
        end
        act_prev = req_active && rst_n;
    end

    logic [7:0] tx_buf[8];
    logic [7:0] rx_buf[8];
    int         tx_len;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            tick(4);
            rx[i]   = spi_miso;
            spi_sck = 1'b1;
            tick(4);
            spi_sck = 1'b0;
        end
    endtask

    task automatic send_bytes(input int n);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            spi_byte(tx_buf[k], b);
            rx_buf[k] = b;
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        tick(4);
    endtask

    task automatic cs_end();
        tick(4);
        spi_cs_n = 1'b1;
        tick(4);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 200) begin
            tick(1);
            i++;
        end
        chk("bus_idle_bound", {31'b0, busy}, 32'h0);
        tick(2);
    endtask

    task automatic clear_recs();
        q_addr.delete(); q_code.delete(); q_wr.delete(); q_data.delete(); q_width.delete();
    endtask

    // Build one frame, run it, and compare against what the frame rules demand
    task automatic run_check(input bit w, input int sz, input logic [5:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int dly);
        int          n;
        logic [31:0] mask, exp_rd;
        logic [7:0]  exp_b;
        logic [1:0]  szb;
        szb  = 2'(sz);
        n    = (sz == 3) ? 2 : (1 << sz);
        mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
        tx_buf[0] = {w, 5'b0, szb};
        tx_buf[1] = {2'b0, addr};
        if (w) begin
            for (int k = 0; k < n; k++) tx_buf[2 + k] = wd[8 * k +: 8];
            tx_len = 2 + n;
        end else begin
            for (int k = 0; k < n + 1; k++) tx_buf[2 + k] = 8'($urandom);
            tx_len = 3 + n;
        end
        periph_data = rd;
        ready_delay = dly;
        clear_recs();
        cs_begin();
        send_bytes(tx_len);
        cs_end();
        wait_idle();
        exp_rd = (dly < 0) ? 32'hFFFF_FFFF : (rd & mask);
        if (sz == 3) begin
            chk("req_count_invalid", q_addr.size(), 32'd0);
        end else begin
            chk("req_count", q_addr.size(), 32'd1);
            if (q_addr.size() == 1) begin
                chk("req_addr", {26'b0, q_addr[0]}, {26'b0, addr});
                chk("req_kind", {31'b0, q_wr[0]}, {31'b0, w});
                chk("req_code", {30'b0, q_code[0]}, {30'b0, szb});
                chk("req_width", q_width[0], (dly < 0) ? TMO : dly + 1);
                if (w) chk("req_wdata", q_data[0], wd & mask);
            end
        end
        for (int k = 0; k < tx_len; k++) begin
            exp_b = (!w && sz != 3 && k >= 3) ? exp_rd[8 * (k - 3) +: 8] : 8'h00;
            chk("miso_byte", {24'b0, rx_buf[k]}, {24'b0, exp_b});
        end
        chk("err_flag", {31'b0, err}, {31'b0, (dly < 0) || (sz == 3)});
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, required finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        int i;
        tick(3);
        chk("rst_write_n", {30'b0, data_write_n}, 32'h3);
        chk("rst_read_n", {30'b0, data_read_n}, 32'h3);
        chk("rst_address", {26'b0, address}, 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_miso", {31'b0, spi_miso}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        rst_n = 1'b1;
        tick(4);

        // 32-bit write, data_ready tied high
        run_check(1'b1, 2, 6'h28, 32'h1122_3344, 32'h0, 0);
        if (q_data.size() > 0) begin
            chk("t1_wdata_lit", q_data[0], 32'h1122_3344);
            chk("t1_width_lit", q_width[0], 32'd1);
            chk("t1_code_lit", {30'b0, q_code[0]}, 32'h2);
        end

        // 8-bit read, ready after 3 cycles, upper data_in bits must be dropped
        run_check(1'b0, 0, 6'h18, 32'h0, 32'h5A5A_5AA5, 3);
        chk("t2_turn_lit", {24'b0, rx_buf[2]}, 32'h00);
        chk("t2_data_lit", {24'b0, rx_buf[3]}, 32'hA5);
        if (q_width.size() > 0) chk("t2_width_lit", q_width[0], 32'd4);

        // 16-bit read timeout
        run_check(1'b0, 1, 6'h21, 32'h0, 32'h1234_5678, -1);
        chk("t3_b0_lit", {24'b0, rx_buf[3]}, 32'hFF);
        chk("t3_b1_lit", {24'b0, rx_buf[4]}, 32'hFF);
        chk("t3_err_lit", {31'b0, err}, 32'h1);

        // cs_n abort after 2 of 4 write data bytes
        ready_delay = 0;
        clear_recs();
        tx_buf[0] = 8'h82; tx_buf[1] = 8'h28; tx_buf[2] = 8'h44; tx_buf[3] = 8'h33;
        cs_begin();
        send_bytes(4);
        cs_end();
        wait_idle();
        chk("abort_no_req", q_addr.size(), 32'd0);
        chk("abort_err", {31'b0, err}, 32'h0);
        run_check(1'b1, 2, 6'h15, 32'hCAFE_F00D, 32'h0, 0);

        // Invalid size header 0x83
        run_check(1'b1, 3, 6'h05, 32'h0000_BEEF, 32'h0, 0);

        // Asynchronous reset in the middle of an outstanding request
        ready_delay = -1;
        clear_recs();
        tx_buf[0] = 8'h01; tx_buf[1] = 8'h07;
        cs_begin();
        send_bytes(2);
        i = 0;
        while (!req_active && i < 50) begin
            tick(1);
            i++;
        end
        chk("rst_mid_req_seen", {31'b0, req_active}, 32'h1);
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_write_n", {30'b0, data_write_n}, 32'h3);
        chk("rstm_read_n", {30'b0, data_read_n}, 32'h3);
        chk("rstm_busy", {31'b0, busy}, 32'h0);
        chk("rstm_err", {31'b0, err}, 32'h0);
        tick(2);
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        rst_n    = 1'b1;
        tick(4);
        clear_recs();

        // Randomized frames
        for (int t = 0; t < 30; t++) begin
            int r, dly, sz;
            r   = $urandom_range(0, 9);
            dly = (r == 9) ? -1 : r % 6;
            sz  = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
            run_check(1'($urandom_range(0, 1)), sz, 6'($urandom), $urandom, $urandom, dly);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
